// File: rtl/ofs_plat_axi_stream_downsizer.sv
// rtl/ofs_plat_axi_stream_downsizer.sv - wide-to-narrow AXI stream converter, optional tail trim via OFS_PLAT_AXIS_DOWNSIZER_TRIM_EN
module ofs_plat_axi_stream_downsizer #(
  parameter int IN_DATA_WIDTH = 512,
  parameter int RATIO = 4,
  parameter int USER_WIDTH = 8,
  localparam int OUT_DATA_WIDTH = IN_DATA_WIDTH / RATIO,
  localparam int IN_KEEP = IN_DATA_WIDTH / 8,
  localparam int OUT_KEEP = OUT_DATA_WIDTH / 8,
  localparam int IDX_W = $clog2(RATIO)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [IN_DATA_WIDTH-1:0]  s_tdata,
  input  logic [IN_KEEP-1:0]        s_tkeep,
  input  logic                      s_tlast,
  input  logic [USER_WIDTH-1:0]     s_tuser,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [OUT_DATA_WIDTH-1:0] m_tdata,
  output logic [OUT_KEEP-1:0]       m_tkeep,
  output logic                      m_tlast,
  output logic [USER_WIDTH-1:0]     m_tuser
);

  typedef enum logic {EMPTY, SERIAL} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         final_idx;
  logic [IDX_W-1:0]         capture_final;
  logic [IN_DATA_WIDTH-1:0] held_data;
  logic [IN_KEEP-1:0]       held_keep;
  logic                     held_last;
  logic [USER_WIDTH-1:0]    held_user;
  logic                     at_final;
  logic                     s_xfer;
  logic                     m_xfer;

  // Handshakes and slice presentation; s_tready intentionally follows m_tready combinationally
  always_comb begin
    at_final = (idx == final_idx);
    m_tvalid = (state == SERIAL);
    s_tready = reset_n && ((state == EMPTY) || (m_tready && at_final));
    s_xfer   = s_tvalid && s_tready;
    m_xfer   = m_tvalid && m_tready;
    m_tdata  = held_data[int'(idx) * OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
    m_tkeep  = held_keep[int'(idx) * OUT_KEEP +: OUT_KEEP];
    m_tlast  = held_last && at_final;
    m_tuser  = held_user;
  end

  // Last slice index for the incoming beat; trim mode drops trailing all-zero-keep slices of a tlast beat
  always_comb begin
    capture_final = IDX_W'(RATIO - 1);
`ifdef OFS_PLAT_AXIS_DOWNSIZER_TRIM_EN
    if (s_tlast) begin
      capture_final = '0;
      for (int i = 1; i < RATIO; i++) begin
        if (|s_tkeep[i * OUT_KEEP +: OUT_KEEP]) capture_final = IDX_W'(i);
      end
    end
`endif
  end

  // Next state: fill when empty, drain to empty only if no new beat is waiting at the final slice
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (s_tvalid) state_next = SERIAL;
      SERIAL:  if (m_tready && at_final && !s_tvalid) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_next;
  end

  // Holding register and slice index; a capture always restarts at slice 0
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx       <= '0;
      final_idx <= '0;
      held_data <= '0;
      held_keep <= '0;
      held_last <= 1'b0;
      held_user <= '0;
    end else if (s_xfer) begin
      idx       <= '0;
      final_idx <= capture_final;
      held_data <= s_tdata;
      held_keep <= s_tkeep;
      held_last <= s_tlast;
      held_user <= s_tuser;
    end else if (m_xfer && !at_final) begin
      idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_ofs_plat_axi_stream_downsizer.sv
// tb/tb_ofs_plat_axi_stream_downsizer.sv - self-checking bench for ofs_plat_axi_stream_downsizer
module tb_ofs_plat_axi_stream_downsizer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         s_tvalid, s_tready, s_tlast;
  logic [511:0] s_tdata;
  logic [63:0]  s_tkeep;
  logic [7:0]   s_tuser;
  logic         m_tvalid, m_tready, m_tlast;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic [7:0]   m_tuser;

  logic         s2_tvalid, s2_tready, m2_tvalid, m2_tready, m2_tlast;
  logic [255:0] m2_tdata;
  logic [31:0]  m2_tkeep;
  logic [7:0]   m2_tuser;

  int vectors = 0;
  int fails = 0;
  bit started = 0;

  typedef struct {logic [127:0] d; logic [15:0] k; logic l; logic [7:0] u;} sl_t;
  typedef struct {logic [255:0] d; logic [31:0] k; logic l; logic [7:0] u;} sl2_t;
  sl_t  q[$];
  sl_t  obs[$];
  sl2_t obs2[$];

  always #5 clk = ~clk;

  ofs_plat_axi_stream_downsizer dut (
    .clk(clk), .reset_n(reset_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser)
  );

  ofs_plat_axi_stream_downsizer #(.IN_DATA_WIDTH(512), .RATIO(2), .USER_WIDTH(8)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .s_tvalid(s2_tvalid), .s_tready(s2_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m2_tvalid), .m_tready(m2_tready), .m_tdata(m2_tdata), .m_tkeep(m2_tkeep),
    .m_tlast(m2_tlast), .m_tuser(m2_tuser)
  );

  function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [511:0] mk(input logic [7:0] b);
    logic [511:0] r;
    for (int i = 0; i < 4; i++) r[i*128 +: 128] = {16{b + 8'(i)}};
    return r;
  endfunction

  // Expected slices of one accepted beat: lowest first, trailing empty slices of a tlast beat dropped in trim mode
  function automatic void push_beat(input logic [511:0] d, input logic [63:0] k, input logic l, input logic [7:0] u);
    int n;
    sl_t s;
    n = 4;
`ifdef OFS_PLAT_AXIS_DOWNSIZER_TRIM_EN
    if (l) begin
      n = 1;
      for (int i = 0; i < 4; i++) if (k[i*16 +: 16] != 16'h0) n = i + 1;
    end
`endif
    for (int i = 0; i < n; i++) begin
      s.d = d[i*128 +: 128];
      s.k = k[i*16 +: 16];
      s.l = l && (i == n - 1);
      s.u = u;
      q.push_back(s);
    end
  endfunction

  // Per-cycle compare against the queue model, then advance the model for the coming edge
  always @(negedge clk) begin
    sl_t cur;
    if (started) begin
      chk("m_tvalid", m_tvalid, q.size() != 0);
      chk("s_tready", s_tready, reset_n && (q.size() == 0 || (q.size() == 1 && m_tready)));
      if (q.size() != 0) begin
        chk("m_tdata", m_tdata, q[0].d);
        chk("m_tkeep", m_tkeep, q[0].k);
        chk("m_tlast", m_tlast, q[0].l);
        chk("m_tuser", m_tuser, q[0].u);
      end
      if (!reset_n) q.delete();
      else begin
        if (m_tvalid && m_tready) begin
          cur.d = m_tdata; cur.k = m_tkeep; cur.l = m_tlast; cur.u = m_tuser;
          obs.push_back(cur);
          if (q.size() != 0) void'(q.pop_front());
        end
        if (s_tvalid && s_tready) push_beat(s_tdata, s_tkeep, s_tlast, s_tuser);
      end
    end
  end

  // Transfer log of the RATIO=2 instance
  always @(negedge clk) begin
    sl2_t c2;
    if (started && reset_n && m2_tvalid && m2_tready) begin
      c2.d = m2_tdata; c2.k = m2_tkeep; c2.l = m2_tlast; c2.u = m2_tuser;
      obs2.push_back(c2);
    end
  end

  task automatic send(input logic [511:0] d, input logic [63:0] k, input logic l, input logic [7:0] u);
    int b;
    logic acc;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u;
    b = 0; acc = 1'b0;
    while (!acc && b < 50) begin
      @(negedge clk); acc = s_tready;
      @(posedge clk); #1; b++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input int n, input string name);
    int b;
    b = 0;
    while ((obs.size() < n || m_tvalid) && b < 100) begin
      @(posedge clk); #1; b++;
    end
    chk({name, "_count"}, obs.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; s_tvalid = 1'b0; s2_tvalid = 1'b0; m_tready = 1'b1; m2_tready = 1'b1;
    s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0;
    @(posedge clk); #1; started = 1;
    @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    @(posedge clk); #1; reset_n = 1'b1;

    // single beat, spec pattern
    obs.delete();
    send({32{16'hAAAA}}, '1, 1'b0, 8'h11);
    @(negedge clk);
    chk("t1_lat_valid", m_tvalid, 1);
    chk("t1_slice0", m_tdata, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
    chk("t1_s_tready", s_tready, 0);
    @(posedge clk); #1;
    drain(4, "t1");
    for (int i = 0; i < 4; i++) chk("t1_last", obs[i].l, 0);

    // back-to-back three beats, last one ends the packet
    obs.delete();
    send(mk(8'h10), '1, 1'b0, 8'h21);
    send(mk(8'h20), '1, 1'b0, 8'h22);
    send(mk(8'h30), '1, 1'b1, 8'h23);
    drain(12, "b2b");
    chk("b2b_slice0", obs[0].d, 128'h1010_1010_1010_1010_1010_1010_1010_1010);
    chk("b2b_slice4", obs[4].d, 128'h2020_2020_2020_2020_2020_2020_2020_2020);
    chk("b2b_slice11_user", obs[11].u, 8'h23);
    for (int i = 0; i < 12; i++) chk("b2b_last", obs[i].l, i == 11);

    // tlast beat with bytes 0..23 enabled
    obs.delete();
    send(mk(8'h50), 64'h0000_0000_00FF_FFFF, 1'b1, 8'h33);
`ifdef OFS_PLAT_AXIS_DOWNSIZER_TRIM_EN
    drain(2, "trim");
    chk("trim_keep1", obs[1].k, 16'h00FF);
    chk("trim_last1", obs[1].l, 1);
`else
    drain(4, "trim");
    chk("trim_keep1", obs[1].k, 16'h00FF);
    chk("trim_keep3", obs[3].k, 16'h0000);
    chk("trim_last2", obs[2].l, 0);
    chk("trim_last3", obs[3].l, 1);
`endif

    // backpressure on slice 1: m_tready 1,0,0,1
    obs.delete();
    send(mk(8'h60), '1, 1'b0, 8'h44);
    m_tready = 1'b1;
    @(posedge clk); #1; m_tready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_stalled_count", obs.size(), 1);
    chk("bp_hold_data", m_tdata, 128'h6161_6161_6161_6161_6161_6161_6161_6161);
    m_tready = 1'b1;
    drain(4, "bp");

    // reset mid-beat after slice 1 transfers
    obs.delete();
    send(mk(8'h70), '1, 1'b0, 8'h55);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_m_tvalid", m_tvalid, 0);
    chk("mid_rst_s_tready", s_tready, 0);
    chk("mid_rst_m_tdata", m_tdata, 0);
    @(posedge clk); #1;
    chk("mid_rst_count", obs.size(), 2);
    reset_n = 1'b1;
    send(mk(8'h80), '1, 1'b0, 8'h66);
    drain(6, "post_rst");
    chk("post_rst_slice0", obs[2].d, 128'h8080_8080_8080_8080_8080_8080_8080_8080);

    // RATIO=2 instance: tuser replication, then zero-keep tlast beat
    obs2.delete();
    s_tdata = mk(8'h40); s_tkeep = '1; s_tlast = 1'b1; s_tuser = 8'h5A; s2_tvalid = 1'b1;
    @(negedge clk); chk("r2_s_tready", s2_tready, 1);
    @(posedge clk); #1; s2_tvalid = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("r2_count", obs2.size(), 2);
    chk("r2_user0", obs2[0].u, 8'h5A);
    chk("r2_user1", obs2[1].u, 8'h5A);
    chk("r2_data0", obs2[0].d[127:0], 128'h4040_4040_4040_4040_4040_4040_4040_4040);
    chk("r2_data1", obs2[1].d[127:0], 128'h4242_4242_4242_4242_4242_4242_4242_4242);
    chk("r2_last0", obs2[0].l, 0);
    chk("r2_last1", obs2[1].l, 1);
    obs2.delete();
    s_tkeep = '0; s2_tvalid = 1'b1;
    @(negedge clk); chk("r2z_s_tready", s2_tready, 1);
    @(posedge clk); #1; s2_tvalid = 1'b0;
    repeat (4) @(posedge clk); #1;
`ifdef OFS_PLAT_AXIS_DOWNSIZER_TRIM_EN
    chk("r2z_count", obs2.size(), 1);
    chk("r2z_keep", obs2[0].k, 0);
    chk("r2z_last", obs2[0].l, 1);
`else
    chk("r2z_count", obs2.size(), 2);
    chk("r2z_keep1", obs2[1].k, 0);
    chk("r2z_last0", obs2[0].l, 0);
    chk("r2z_last1", obs2[1].l, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/ofs_plat_axi_stream_downsizer.md
Name: ofs_plat_axi_stream_downsizer

Overview:
- AXI stream width converter, wide-to-narrow, placed directly downstream of the stream skid buffer.
- Accepts one wide beat, holds it, and emits it as RATIO narrow slices, lowest slice first.
- Supports full throughput: a new wide beat is accepted in the same cycle the final slice of the current beat is consumed.
- Feeds narrow-datapath consumers such as CSR/MMIO engines and narrow host channels.

Parameters:
- IN_DATA_WIDTH, 512: input tdata width in bits. Multiple of 8*RATIO.
- RATIO, 4: slices per input beat. Power of 2, range 2..16.
- USER_WIDTH, 8: tuser width. Replicated unchanged onto every slice.
- Derived: OUT_DATA_WIDTH = IN_DATA_WIDTH/RATIO; IN_KEEP = IN_DATA_WIDTH/8; OUT_KEEP = OUT_DATA_WIDTH/8; IDX_W = log2(RATIO).

Ports:
- clk  in  1  clock; the only clock
- reset_n  in  1  reset, synchronous, active-low
- s_tvalid  in  1  input beat valid
- s_tready  out  1  input ready
- s_tdata  in  IN_DATA_WIDTH  input data
- s_tkeep  in  IN_KEEP  input byte enables
- s_tlast  in  1  end of packet
- s_tuser  in  USER_WIDTH  sideband
- m_tvalid  out  1  slice valid
- m_tready  in  1  downstream ready
- m_tdata  out  OUT_DATA_WIDTH  slice data
- m_tkeep  out  OUT_KEEP  slice byte enables
- m_tlast  out  1  last slice of packet
- m_tuser  out  USER_WIDTH  sideband copy

Behaviour:
- Reset (reset_n low at clk edge): state EMPTY, idx=0, holding register cleared, m_tvalid=0, m_tdata/m_tkeep/m_tuser=0, m_tlast=0. s_tready is 0 while reset_n is low. Reset mid-packet discards the held beat with no partial output; first slice after reset is slice 0 of a new beat.
- States:
  - EMPTY: holding register invalid; s_tready=1; m_tvalid=0.
  - SERIAL: holding register valid; m_tvalid=1; m_tdata/m_tkeep = slice idx of held data/keep.
- Transitions:
  - EMPTY -> SERIAL on s_tvalid&&s_tready. Captures data/keep/last/user, sets idx=0, and computes final_idx.
  - In SERIAL, a slice transfers on m_tvalid&&m_tready.
    - Transfer with idx != final_idx: idx increments; state stays SERIAL.
    - Transfer with idx == final_idx and s_tvalid=1: captures the new beat in the same cycle; state stays SERIAL; idx=0.
    - Transfer with idx == final_idx and s_tvalid=0: state goes to EMPTY.
- s_tready = (state==EMPTY) || (m_tready && idx==final_idx). This combinational path from m_tready is intentional; the upstream skid breaks it.
- final_idx:
  - Non-tlast beat: RATIO-1.
  - tlast beat: depends on the optional feature (below).
- m_tlast = held_last && (idx==final_idx). Asserted only on the final slice of a tlast beat.
- m_tuser = held tuser on every slice of the beat.
- Latency: input beat accepted at edge N produces slice 0 valid in cycle N+1. Sustained rate is 1 slice/cycle; no bubble between beats when s_tvalid is held.
- Outputs are stable while m_tvalid && !m_tready (AXI hold rule).
- idx wraps only via the final-slice rule; it never exceeds final_idx.
- Input tkeep is not required to be contiguous; slices are emitted with their keep bits verbatim.

Optional Feature:
- Macro: OFS_PLAT_AXIS_DOWNSIZER_TRIM_EN.
- Defined: on a tlast beat, final_idx = index of the highest slice with any nonzero keep bit.
  - Trailing empty slices are dropped.
  - If keep is all zero, final_idx = 0: one slice with tkeep=0 and m_tlast=1.
  - Computed by a priority encoder at capture time and registered.
- Undefined: final_idx = RATIO-1 always; trailing slices are emitted with tkeep=0, and m_tlast is set on slice RATIO-1.

Test Plan:
- Single beat, defaults, tdata=512'h{16'hAAAA..}, keep all 1, tlast=0, m_tready=1: 4 slices of 128b, slice0=tdata[127:0] in cycle N+1, s_tready=0 for cycles N+1..N+3, m_tlast=0 on all.
- Back-to-back 3 beats, s_tvalid held, m_tready=1: 12 consecutive slices, no m_tvalid gap, s_tready high on the final-slice cycles only. On the 3rd beat (tlast=1), m_tlast on slice 11 only.
- TRIM_EN, tlast beat with keep=64'h0000_0000_00FF_FFFF (bytes 0..23): 2 slices emitted, slice1 tkeep=16'h00FF, m_tlast=1. Without the macro: 4 slices, slices 2..3 tkeep=0, m_tlast on slice 3.
- Backpressure: m_tready toggles 1,0,0,1 during slice 1: m_tdata/m_tkeep/m_tuser/m_tlast unchanged while stalled, idx advances only on handshake cycles, s_tready stays 0.
- Reset asserted in cycle after slice 1 transfer of a 4-slice beat: next edge m_tvalid=0, s_tready stays 0 while reset_n is low. After release, a new beat yields its slice 0; no stale slices 2..3 appear.
- tuser=8'h5A on a beat with RATIO=2 param override: both 256b slices carry m_tuser=8'h5A. A zero-keep tlast beat under TRIM_EN yields one slice, tkeep=0, m_tlast=1.
